alu_exec_unit: RTL and testbench

//  Execute-stage ALU that consumes the 4-bit select code from the ALU control unit plus two operands.

---
 rtl/alu_exec_unit.sv | 159 +++++++++++++++
 tb/tb_alu_exec_unit.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU between ALU control and writeback/branch compare.
// AND/OR/ADD/SUB finish on the accept edge; SLL/SRL shift one bit per cycle.
// One request in flight: a new request is taken only in IDLE, and a result
// is held in DONE until the consumer takes it.
module alu_exec_unit #(
  parameter int WIDTH = 32,
  parameter int SH_W  = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [3:0]       i_select,
  input  logic [WIDTH-1:0] i_op_a,
  input  logic [WIDTH-1:0] i_op_b,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_zero,
  output logic             o_ovf,
  output logic             o_illegal
);

  localparam logic [3:0] SEL_AND = 4'b0000;
  localparam logic [3:0] SEL_OR  = 4'b0001;
  localparam logic [3:0] SEL_ADD = 4'b0010;
  localparam logic [3:0] SEL_SUB = 4'b0110;
  localparam logic [3:0] SEL_SLL = 4'b0011;
  localparam logic [3:0] SEL_SRL = 4'b0100;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_stateNext;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] w_resultNext;
  logic [SH_W-1:0]  r_count;
  logic [SH_W-1:0]  w_countNext;
  logic             r_shiftLeft;
  logic             w_shiftLeftNext;
  logic             r_zero;
  logic             w_zeroNext;
  logic             r_ovf;
  logic             w_ovfNext;
  logic             r_illegal;
  logic             w_illegalNext;

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic             w_addOvf;
  logic             w_subOvf;
  logic [SH_W-1:0]  w_shamt;
  logic [WIDTH-1:0] w_shifted;

  // Arithmetic, overflow detection and the single-bit shift step shared by the FSM.
  always_comb begin
    w_sum     = i_op_a + i_op_b;
    w_diff    = i_op_a - i_op_b;
    w_addOvf  = (i_op_a[WIDTH-1] == i_op_b[WIDTH-1]) && (w_sum[WIDTH-1] != i_op_a[WIDTH-1]);
    w_subOvf  = (i_op_a[WIDTH-1] != i_op_b[WIDTH-1]) && (w_diff[WIDTH-1] != i_op_a[WIDTH-1]);
    w_shamt   = i_op_b[SH_W-1:0];
    w_shifted = r_shiftLeft ? {r_result[WIDTH-2:0], 1'b0} : {1'b0, r_result[WIDTH-1:1]};
  end

  // Next-state and next-datapath logic; every register holds unless a branch below updates it.
  always_comb begin
    w_stateNext     = r_state;
    w_resultNext    = r_result;
    w_countNext     = r_count;
    w_shiftLeftNext = r_shiftLeft;
    w_zeroNext      = r_zero;
    w_ovfNext       = r_ovf;
    w_illegalNext   = r_illegal;

    case (r_state)
      S_IDLE: begin
        if (i_in_valid) begin
          w_ovfNext     = 1'b0;
          w_illegalNext = 1'b0;
          w_stateNext   = S_DONE;
          case (i_select)
            SEL_AND: w_resultNext = i_op_a & i_op_b;
            SEL_OR:  w_resultNext = i_op_a | i_op_b;
            SEL_ADD: begin
              w_resultNext = w_sum;
              w_ovfNext    = w_addOvf;
            end
            SEL_SUB: begin
              w_resultNext = w_diff;
              w_ovfNext    = w_subOvf;
            end
            SEL_SLL, SEL_SRL: begin
              w_resultNext    = i_op_a;
              w_countNext     = w_shamt;
              w_shiftLeftNext = (i_select == SEL_SLL);
              if (w_shamt != '0) begin
                w_stateNext = S_SHIFT;
              end
            end
            default: begin
              w_resultNext  = '0;
              w_illegalNext = 1'b1;
            end
          endcase
        end
      end
      S_SHIFT: begin
        w_resultNext = w_shifted;
        w_countNext  = r_count - SH_W'(1);
        if (r_count == SH_W'(1)) begin
          w_stateNext = S_DONE;
        end
      end
      S_DONE: begin
        if (i_out_ready) begin
          w_stateNext = S_IDLE;
        end
      end
      default: w_stateNext = S_IDLE;
    endcase

    if ((r_state != S_DONE) && (w_stateNext == S_DONE)) begin
      w_zeroNext = (w_resultNext == '0);
    end
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_result    <= '0;
      r_count     <= '0;
      r_shiftLeft <= 1'b0;
      r_zero      <= 1'b1;
      r_ovf       <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_result    <= w_resultNext;
      r_count     <= w_countNext;
      r_shiftLeft <= w_shiftLeftNext;
      r_zero      <= w_zeroNext;
      r_ovf       <= w_ovfNext;
      r_illegal   <= w_illegalNext;
    end
  end

  assign o_in_ready  = (r_state == S_IDLE);
  assign o_out_valid = (r_state == S_DONE);
  assign o_result    = r_result;
  assign o_zero      = r_zero;
  assign o_ovf       = r_ovf;
  assign o_illegal   = r_illegal;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed and random requests for alu_exec_unit, checked against
// an arithmetic reference model of the select codes.
module tb_alu_exec_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rstN;
  logic         inValid;
  logic         inReady;
  logic [3:0]   sel;
  logic [W-1:0] opA;
  logic [W-1:0] opB;
  logic         outValid;
  logic         outReady;
  logic [W-1:0] result;
  logic         zero;
  logic         ovf;
  logic         illegal;

  int nChecks = 0;
  int nFails  = 0;

  alu_exec_unit #(.WIDTH(W), .SH_W(5)) dut (
    .i_clk       (clk),
    .i_rst_n     (rstN),
    .i_in_valid  (inValid),
    .o_in_ready  (inReady),
    .i_select    (sel),
    .i_op_a      (opA),
    .i_op_b      (opB),
    .o_out_valid (outValid),
    .i_out_ready (outReady),
    .o_result    (result),
    .o_zero      (zero),
    .o_ovf       (ovf),
    .o_illegal   (illegal)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Hard stop in case the design never responds.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model: the true signed result is compared with the wrapped one to find overflow.
  task automatic modelOp(input logic [3:0] s, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] res, output logic expOvf, output logic expIll,
                         output int lat);
    longint trueVal;
    int     shamt;
    shamt   = int'(b[4:0]);
    expOvf  = 1'b0;
    expIll  = 1'b0;
    lat     = 1;
    trueVal = 0;
    case (s)
      4'd0: res = a & b;
      4'd1: res = a | b;
      4'd2: begin
        trueVal = longint'($signed(a)) + longint'($signed(b));
        res     = a + b;
        expOvf  = (trueVal != longint'($signed(res)));
      end
      4'd6: begin
        trueVal = longint'($signed(a)) - longint'($signed(b));
        res     = a - b;
        expOvf  = (trueVal != longint'($signed(res)));
      end
      4'd3: begin
        res = a << shamt;
        lat = shamt + 1;
      end
      4'd4: begin
        res = a >> shamt;
        lat = shamt + 1;
      end
      default: begin
        res    = '0;
        expIll = 1'b1;
      end
    endcase
  endtask

  // Issue one request, wait for its result, check it, then hand it off.
  task automatic applyStimulus(input string tag, input logic [3:0] s,
                               input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] expRes;
    logic         expOvf;
    logic         expIll;
    int           expLat;
    int           cycles;
    modelOp(s, a, b, expRes, expOvf, expIll, expLat);
    @(negedge clk);
    checkOutput({tag, " in_ready idle"}, W'(inReady), W'(1));
    inValid = 1'b1;
    sel     = s;
    opA     = a;
    opB     = b;
    @(posedge clk);
    #1;
    inValid = 1'b0;
    sel     = 4'($urandom);
    opA     = $urandom;
    opB     = $urandom;
    cycles  = 1;
    while (outValid !== 1'b1 && cycles < 64) begin
      checkOutput({tag, " in_ready busy"}, W'(inReady), W'(0));
      @(posedge clk);
      #1;
      cycles++;
    end
    checkOutput({tag, " latency"}, W'(cycles), W'(expLat));
    checkOutput({tag, " result"}, result, expRes);
    checkOutput({tag, " zero"}, W'(zero), W'(expRes == '0));
    checkOutput({tag, " ovf"}, W'(ovf), W'(expOvf));
    checkOutput({tag, " illegal"}, W'(illegal), W'(expIll));
    checkOutput({tag, " in_ready done"}, W'(inReady), W'(0));
    outReady = 1'b1;
    @(posedge clk);
    #1;
    outReady = 1'b0;
    checkOutput({tag, " out_valid drop"}, W'(outValid), W'(0));
    checkOutput({tag, " in_ready back"}, W'(inReady), W'(1));
  endtask

  initial begin
    logic [3:0]   rs;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [3:0]   legalCodes [6];

    rstN     = 1'b0;
    inValid  = 1'b0;
    outReady = 1'b0;
    sel      = 4'd0;
    opA      = '0;
    opB      = '0;

    // Reset values.
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset in_ready", W'(inReady), W'(1));
    checkOutput("reset out_valid", W'(outValid), W'(0));
    checkOutput("reset result", result, '0);
    checkOutput("reset zero", W'(zero), W'(1));
    checkOutput("reset ovf", W'(ovf), W'(0));
    checkOutput("reset illegal", W'(illegal), W'(0));
    rstN = 1'b1;
    $display("[TB] reset released");

    // Directed arithmetic and logic cases.
    applyStimulus("add ovf", 4'b0010, 32'h7FFF_FFFF, 32'h0000_0001);
    applyStimulus("sub zero", 4'b0110, 32'd5, 32'd5);
    applyStimulus("and", 4'b0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    applyStimulus("or", 4'b0001, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    applyStimulus("sub ovf", 4'b0110, 32'h8000_0000, 32'd1);
    applyStimulus("add neg wrap", 4'b0010, 32'hFFFF_FFFF, 32'h0000_0001);

    // Shifts, including the full-width and zero-distance boundaries.
    applyStimulus("sll 31", 4'b0011, 32'd1, 32'd31);
    applyStimulus("srl 4", 4'b0100, 32'h8000_0000, 32'h0000_0024);
    applyStimulus("sll 0", 4'b0011, 32'hDEAD_BEEF, 32'hFFFF_FFE0);
    applyStimulus("srl 0", 4'b0100, 32'h1234_5678, 32'd0);

    // Illegal codes.
    applyStimulus("illegal 1111", 4'b1111, 32'h1234_5678, 32'h1);
    applyStimulus("illegal 0101", 4'b0101, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // Backpressure: result held and new requests ignored while DONE waits.
    @(negedge clk);
    inValid = 1'b1;
    sel     = 4'b0010;
    opA     = 32'd3;
    opB     = 32'd4;
    @(posedge clk);
    #1;
    sel = 4'b0000;
    opA = 32'hFFFF_FFFF;
    opB = 32'h0;
    for (int i = 0; i < 10; i++) begin
      checkOutput("bp out_valid", W'(outValid), W'(1));
      checkOutput("bp result", result, 32'd7);
      checkOutput("bp in_ready", W'(inReady), W'(0));
      @(posedge clk);
      #1;
    end
    inValid  = 1'b0;
    outReady = 1'b1;
    @(posedge clk);
    #1;
    outReady = 1'b0;
    checkOutput("bp release out_valid", W'(outValid), W'(0));
    checkOutput("bp release in_ready", W'(inReady), W'(1));
    checkOutput("bp release result", result, 32'd7);

    // Reset in the middle of a long shift.
    @(negedge clk);
    inValid = 1'b1;
    sel     = 4'b0011;
    opA     = 32'd1;
    opB     = 32'd20;
    @(posedge clk);
    #1;
    inValid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
    end
    #3;
    checkOutput("pre-reset busy", W'(inReady), W'(0));
    rstN = 1'b0;
    #1;
    checkOutput("async reset out_valid", W'(outValid), W'(0));
    checkOutput("async reset in_ready", W'(inReady), W'(1));
    checkOutput("async reset result", result, '0);
    checkOutput("async reset zero", W'(zero), W'(1));
    @(negedge clk);
    rstN = 1'b1;
    applyStimulus("add after reset", 4'b0010, 32'd1, 32'd1);

    // Random requests across legal and illegal codes.
    legalCodes[0] = 4'b0000;
    legalCodes[1] = 4'b0001;
    legalCodes[2] = 4'b0010;
    legalCodes[3] = 4'b0110;
    legalCodes[4] = 4'b0011;
    legalCodes[5] = 4'b0100;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        rs = 4'($urandom_range(0, 15));
      end else begin
        rs = legalCodes[$urandom_range(0, 5)];
      end
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 7) == 0) begin
        rb = ra;
      end
      applyStimulus("random", rs, ra, rb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
